// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: ALU control codes and mul/div op decode shared by the unit and its users
`ifndef ALU_DEFINES
`define ALU_DEFINES
`define ALUCtrl_MULT  5'b10000
`define ALUCtrl_MULTU 5'b10001
`define ALUCtrl_DIV   5'b10010
`define ALUCtrl_DIVU  5'b10011
`endif

package mul_div_unit_pkg;

    typedef struct packed {
        logic valid;
        logic sgn;
        logic div;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [4:0] op);
        md_dec_t d;
        d.valid = op == `ALUCtrl_MULT || op == `ALUCtrl_MULTU ||
                  op == `ALUCtrl_DIV  || op == `ALUCtrl_DIVU;
        d.sgn   = op == `ALUCtrl_MULT || op == `ALUCtrl_DIV;
        d.div   = op == `ALUCtrl_DIV  || op == `ALUCtrl_DIVU;
        return d;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_if: request, MTHI/MTLO write and HI/LO result bundle of the mul/div unit
//   master drives start/op/a/b/hi_we/lo_we/wdata; slave drives busy/done/stall/hi/lo
interface mul_div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// md_sign_fix: conditional two's-complement negation (abs of an operand or signed result fix-up)
//   val_i value, neg_i negate when set, res_o result
module md_sign_fix #(parameter int W = 32) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one bit per cycle
//   clk, rstn (async active-low), md: slave side of mul_div_if
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rstn,
    mul_div_if.slave    md
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opr_q, opr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_q, neg_d, rsgn_q, rsgn_d, done_q, done_d;

    md_dec_t            dec;
    logic [WIDTH-1:0]   abs_a, abs_b, quot, rem, sub;
    logic [2*WIDTH-1:0] prod, mul_step, div_step;
    logic [WIDTH:0]     sum;
    logic               ge;

    assign dec = md_decode(md.op);

    md_sign_fix #(.W(WIDTH))   u_abs_a (.val_i(md.a), .neg_i(dec.sgn & md.a[WIDTH-1]), .res_o(abs_a));
    md_sign_fix #(.W(WIDTH))   u_abs_b (.val_i(md.b), .neg_i(dec.sgn & md.b[WIDTH-1]), .res_o(abs_b));
    md_sign_fix #(.W(2*WIDTH)) u_prod  (.val_i(acc_q), .neg_i(neg_q), .res_o(prod));
    md_sign_fix #(.W(WIDTH))   u_quot  (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .res_o(quot));
    md_sign_fix #(.W(WIDTH))   u_rem   (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rsgn_q), .res_o(rem));

    // Multiply: acc = {partial, multiplier}; add multiplicand on the low bit, shift right with carry.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opr_q};
    assign mul_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend}; the shifted remainder needs WIDTH+1 bits to compare,
    // but after a successful subtract it is below the divisor, so WIDTH bits hold the difference.
    assign ge       = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opr_q};
    assign sub      = acc_q[2*WIDTH-2:WIDTH-1] - opr_q;
    assign div_step = ge ? {sub, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opr_d   = opr_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rsgn_d  = rsgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (md.start && dec.valid) begin
                    div_d   = dec.div;
                    neg_d   = dec.sgn & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
                    rsgn_d  = dec.div & dec.sgn & md.a[WIDTH-1];
                    opr_d   = dec.div ? abs_b : abs_a;
                    acc_d   = {{WIDTH{1'b0}}, dec.div ? abs_a : abs_b};
                    cnt_d   = '0;
                    state_d = S_CALC;
                    // Divide by zero: preload the raw result and let FIX commit it unchanged.
                    if (dec.div && md.b == '0) begin
                        acc_d   = {md.a, {WIDTH{1'b1}}};
                        neg_d   = 1'b0;
                        rsgn_d  = 1'b0;
                        state_d = S_FIX;
                    end
                end else begin
                    hi_d = md.hi_we ? md.wdata : hi_q;
                    lo_d = md.lo_we ? md.wdata : lo_q;
                end
            end
            S_CALC: begin
                acc_d   = div_q ? div_step : mul_step;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quot : prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            opr_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rsgn_q  <= rsgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign md.busy  = state_q != S_IDLE;
    assign md.done  = done_q;
    assign md.stall = md.busy | (md.start & dec.valid);
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit against a 64-bit arithmetic model
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(W)) bus();
    mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .md(bus));

    int errs = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [4:0] ops[4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == `ALUCtrl_MULT) return sa * sb;
        if (op == `ALUCtrl_MULTU) return ua * ub;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == `ALUCtrl_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        exp_q.push_back(model(op, a, b));
    endtask

    task automatic wait_done(input string tag, output int lat, output int stalls);
        logic [63:0] e;
        lat = 0;
        #1 stalls = int'(bus.stall);
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            #1 lat++;
            if (bus.stall) stalls++;
        end while (!bus.done && lat < 100);
        e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
        check({tag, " done"}, {63'd0, bus.done}, 64'd1);
        check({tag, " busy@done"}, {63'd0, bus.busy}, 64'd0);
        check({tag, " hi:lo"}, {bus.hi, bus.lo}, e);
        @(negedge clk);
        check({tag, " done width"}, {63'd0, bus.done}, 64'd0);
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    initial begin
        int lat, st, n;
        logic [31:0] h0;
        ops = '{`ALUCtrl_MULT, `ALUCtrl_MULTU, `ALUCtrl_DIV, `ALUCtrl_DIVU};
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset done", {63'd0, bus.done}, 64'd0);
        check("reset stall", {63'd0, bus.stall}, 64'd0);
        check("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        issue(`ALUCtrl_MULT, 32'd7, 32'hFFFF_FFFD);
        check("mult busy@start", {63'd0, bus.busy}, 64'd0);
        check("mult const", {bus.hi, bus.lo}, 64'd0);
        wait_done("mult", lat, st);
        check("mult latency", 64'(lat), 64'd34);
        check("mult stall cycles", 64'(st), 64'd34);
        check("mult hi:lo const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        issue(`ALUCtrl_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", lat, st);
        check("multu const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

        issue(`ALUCtrl_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div neg", lat, st);
        check("div neg const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(`ALUCtrl_DIVU, 32'd100, 32'd7);
        wait_done("divu", lat, st);
        check("divu const", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
        issue(`ALUCtrl_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div wrap", lat, st);
        check("div wrap const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        for (int i = 0; i < 8; i++) begin
            issue(ops[$urandom_range(0, 3)], $urandom, (i == 3) ? 32'd0 : $urandom);
            wait_done("random", lat, st);
        end

        issue(`ALUCtrl_DIV, 32'h1234_5678, 32'd0);
        wait_done("div0", lat, st);
        check("div0 latency", 64'(lat), 64'd2);
        check("div0 stall cycles", 64'(st), 64'd2);
        check("div0 const", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);

        write_hilo(1'b1, 1'b0, 32'hA5A5_A5A5);
        check("mthi", {bus.hi, bus.lo}, 64'hA5A5_A5A5_FFFF_FFFF);
        write_hilo(1'b0, 1'b1, 32'h5A5A_0001);
        check("mtlo", {bus.hi, bus.lo}, 64'hA5A5_A5A5_5A5A_0001);

        h0 = bus.hi;
        issue(`ALUCtrl_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        bus.op = `ALUCtrl_MULT;
        bus.a = 32'd5;
        bus.b = 32'd5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi while busy", {32'd0, bus.hi}, {32'd0, h0});
        wait_done("restart ignored", lat, st);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("no second done", 64'(n), 64'd0);

        issue(`ALUCtrl_MULT, 32'h0001_0003, 32'h0002_0005);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort busy", {63'd0, bus.busy}, 64'd0);
        check("abort hi:lo", {bus.hi, bus.lo}, 64'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("abort no done", 64'(n), 64'd0);

        issue(`ALUCtrl_MULT, 32'd3, 32'd4);
        wait_done("mult after abort", lat, st);
        check("mult 3*4 const", {bus.hi, bus.lo}, 64'd12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
